// File: rtl/adder_result_accumulator.sv
// Sums NUM_SAMPLES adder results (0..6) into a saturating accumulator and
// hands the window total downstream over a valid/ready handshake.
module adder_result_accumulator #(
   parameter int ACC_WIDTH   = 8,
   parameter int NUM_SAMPLES = 4,
   parameter int CNT_WIDTH   = $clog2(NUM_SAMPLES + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [2:0]           i_result,
   input  logic                 i_result_valid,
   output logic                 o_result_ready,
   input  logic                 i_clear,
   output logic [ACC_WIDTH-1:0] o_sum,
   output logic [CNT_WIDTH-1:0] o_count,
   output logic                 o_sum_valid,
   input  logic                 i_sum_ready,
   output logic                 o_overflow
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NUM_SAMPLES);

   state_t                 r_state;
   logic [ACC_WIDTH-1:0]   r_acc;
   logic [CNT_WIDTH-1:0]   r_count;
   logic                   r_overflow;

   logic [ACC_WIDTH:0]     w_sum_wide;
   logic                   w_sat;
   logic [CNT_WIDTH-1:0]   w_count_inc;

   // One extra bit is enough: the largest true sum is (2^ACC_WIDTH-1)+6.
   assign w_sum_wide  = {1'b0, r_acc} + (ACC_WIDTH + 1)'(i_result);
   assign w_sat       = w_sum_wide[ACC_WIDTH];
   assign w_count_inc = r_count + CNT_WIDTH'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_ACCUM;
         r_acc      <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (i_clear) begin
                  r_acc      <= '0;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
               end else if (i_result_valid) begin
                  r_acc   <= w_sat ? {ACC_WIDTH{1'b1}} : w_sum_wide[ACC_WIDTH-1:0];
                  r_count <= w_count_inc;
                  if (w_sat) begin
                     r_overflow <= 1'b1;
                  end
                  if (w_count_inc == CNT_LAST) begin
                     r_state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (i_sum_ready) begin
                  r_state    <= ST_ACCUM;
                  r_acc      <= '0;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_ACCUM;
            end
         endcase
      end
   end

   // Ready is gated by reset so nothing is offered as accepted while in reset.
   assign o_result_ready = (r_state == ST_ACCUM) && i_rst_n;
   assign o_sum_valid    = (r_state == ST_HOLD);
   assign o_sum          = r_acc;
   assign o_count        = r_count;
   assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: three instances (8b/4, 3b/4, 8b/1),
// directed scenarios plus randomized traffic against a window-level model.
module tb_adder_result_accumulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid  [3];
   logic [2:0] res    [3];
   logic       clr    [3];
   logic       sready [3];
   logic       ready  [3];
   logic       svalid [3];
   logic       ovf    [3];
   logic [7:0] sum_a, sum_c;
   logic [2:0] sum_b;
   logic [2:0] cnt_a, cnt_b;
   logic [0:0] cnt_c;
   logic [7:0] sum [3];
   logic [2:0] cnt [3];

   int n_cmp = 0;
   int n_bad = 0;

   // Window model: running total clipped at the width limit, samples seen,
   // whether a finished total is waiting, and whether the clip happened.
   int m_sum  [3];
   int m_cnt  [3];
   bit m_hold [3];
   bit m_ovf  [3];

   always #5 clk = ~clk;

   assign sum[0] = sum_a;
   assign sum[1] = {5'd0, sum_b};
   assign sum[2] = sum_c;
   assign cnt[0] = cnt_a;
   assign cnt[1] = cnt_b;
   assign cnt[2] = {2'd0, cnt_c};

   adder_result_accumulator #(.ACC_WIDTH(8), .NUM_SAMPLES(4)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_result(res[0]), .i_result_valid(valid[0]),
      .o_result_ready(ready[0]), .i_clear(clr[0]), .o_sum(sum_a), .o_count(cnt_a),
      .o_sum_valid(svalid[0]), .i_sum_ready(sready[0]), .o_overflow(ovf[0]));

   adder_result_accumulator #(.ACC_WIDTH(3), .NUM_SAMPLES(4)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_result(res[1]), .i_result_valid(valid[1]),
      .o_result_ready(ready[1]), .i_clear(clr[1]), .o_sum(sum_b), .o_count(cnt_b),
      .o_sum_valid(svalid[1]), .i_sum_ready(sready[1]), .o_overflow(ovf[1]));

   adder_result_accumulator #(.ACC_WIDTH(8), .NUM_SAMPLES(1)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_result(res[2]), .i_result_valid(valid[2]),
      .o_result_ready(ready[2]), .i_clear(clr[2]), .o_sum(sum_c), .o_count(cnt_c),
      .o_sum_valid(svalid[2]), .i_sum_ready(sready[2]), .o_overflow(ovf[2]));

   function automatic int lim(int d);
      return (d == 1) ? 7 : 255;
   endfunction

   function automatic int nsamp(int d);
      return (d == 2) ? 1 : 4;
   endfunction

   task automatic tick();
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            m_hold[d] = 0; m_sum[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0;
         end else if (m_hold[d]) begin
            if (sready[d]) begin
               m_hold[d] = 0; m_sum[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0;
            end
         end else if (clr[d]) begin
            m_sum[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0;
         end else if (valid[d]) begin
            m_sum[d] = m_sum[d] + int'(res[d]);
            if (m_sum[d] > lim(d)) begin
               m_sum[d] = lim(d);
               m_ovf[d] = 1;
            end
            m_cnt[d]++;
            if (m_cnt[d] == nsamp(d)) m_hold[d] = 1;
         end
      end
      #1;
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         valid[d] = 0; res[d] = 3'd0; clr[d] = 0; sready[d] = 0;
      end
   endtask

   task automatic hard_reset();
      idle_all();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle_all();
      rst_n = 0;
      tick();
      for (int d = 0; d < 3; d++) begin
         n_cmp++; if (sum[d] !== 8'd0) begin n_bad++; $display("FAIL reset_sum[%0d]: got %0d want 0", d, sum[d]); end
         n_cmp++; if (cnt[d] !== 3'd0) begin n_bad++; $display("FAIL reset_cnt[%0d]: got %0d want 0", d, cnt[d]); end
         n_cmp++; if (svalid[d] !== 1'b0 || ovf[d] !== 1'b0) begin n_bad++; $display("FAIL reset_flags[%0d]: got v=%b o=%b want 0 0", d, svalid[d], ovf[d]); end
         n_cmp++; if (ready[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low[%0d]: got %b want 0", d, ready[d]); end
      end
      rst_n = 1;
      #1;
      n_cmp++; if (ready[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ready_release: got %b want 1", ready[0]); end
   endtask

   task automatic test_basic_window();
      int vals[4] = '{3, 6, 1, 2};
      hard_reset();
      for (int i = 0; i < 4; i++) begin
         valid[0] = 1; res[0] = 3'(vals[i]); sready[0] = 1;
         tick();
         n_cmp++; if (cnt[0] !== 3'(i + 1)) begin n_bad++; $display("FAIL basic_cnt: got %0d want %0d", cnt[0], i + 1); end
      end
      valid[0] = 0;
      n_cmp++; if (svalid[0] !== 1'b1 || sum[0] !== 8'd12 || ovf[0] !== 1'b0) begin n_bad++; $display("FAIL basic_total: got v=%b s=%0d o=%b want 1 12 0", svalid[0], sum[0], ovf[0]); end
      n_cmp++; if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL basic_ready_hold: got %b want 0", ready[0]); end
      tick();
      n_cmp++; if (svalid[0] !== 1'b0 || cnt[0] !== 3'd0 || ready[0] !== 1'b1) begin n_bad++; $display("FAIL basic_after: got v=%b c=%0d r=%b want 0 0 1", svalid[0], cnt[0], ready[0]); end
   endtask

   task automatic test_back_pressure();
      int vals[4] = '{3, 6, 1, 2};
      hard_reset();
      for (int i = 0; i < 4; i++) begin
         valid[0] = 1; res[0] = 3'(vals[i]);
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         valid[0] = 1; res[0] = 3'($urandom_range(0, 6));
         tick();
         n_cmp++; if (svalid[0] !== 1'b1 || sum[0] !== 8'd12 || cnt[0] !== 3'd4 || ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_hold: got v=%b s=%0d c=%0d r=%b want 1 12 4 0", svalid[0], sum[0], cnt[0], ready[0]); end
      end
      valid[0] = 0; sready[0] = 1;
      tick();
      sready[0] = 0; valid[0] = 1; res[0] = 3'd5;
      tick();
      valid[0] = 0;
      n_cmp++; if (sum[0] !== 8'd5 || cnt[0] !== 3'd1 || svalid[0] !== 1'b0) begin n_bad++; $display("FAIL bp_restart: got s=%0d c=%0d v=%b want 5 1 0", sum[0], cnt[0], svalid[0]); end
   endtask

   task automatic test_saturation();
      int va[4] = '{6, 6, 0, 0};
      int vb[4] = '{3, 4, 0, 0};
      hard_reset();
      for (int i = 0; i < 4; i++) begin
         valid[1] = 1; res[1] = 3'(va[i]);
         tick();
         n_cmp++; if (ovf[1] !== (i >= 1)) begin n_bad++; $display("FAIL sat_ovf[%0d]: got %b want %b", i, ovf[1], i >= 1); end
      end
      valid[1] = 0;
      n_cmp++; if (sum[1] !== 8'd7 || svalid[1] !== 1'b1) begin n_bad++; $display("FAIL sat_total: got s=%0d v=%b want 7 1", sum[1], svalid[1]); end
      sready[1] = 1;
      tick();
      sready[1] = 0;
      n_cmp++; if (ovf[1] !== 1'b0 || sum[1] !== 8'd0) begin n_bad++; $display("FAIL sat_clear: got o=%b s=%0d want 0 0", ovf[1], sum[1]); end
      for (int i = 0; i < 4; i++) begin
         valid[1] = 1; res[1] = 3'(vb[i]);
         tick();
      end
      valid[1] = 0;
      n_cmp++; if (sum[1] !== 8'd7 || ovf[1] !== 1'b0 || svalid[1] !== 1'b1) begin n_bad++; $display("FAIL sat_exact: got s=%0d o=%b v=%b want 7 0 1", sum[1], ovf[1], svalid[1]); end
   endtask

   task automatic test_valid_gaps();
      bit pat[7] = '{1, 0, 1, 1, 0, 0, 1};
      int seen = 0;
      hard_reset();
      for (int i = 0; i < 7; i++) begin
         valid[0] = pat[i];
         res[0] = pat[i] ? 3'd5 : 3'bx;
         tick();
         seen += int'(pat[i]);
         n_cmp++; if (cnt[0] !== 3'(seen) || svalid[0] !== (i == 6)) begin n_bad++; $display("FAIL gaps[%0d]: got c=%0d v=%b want %0d %b", i, cnt[0], svalid[0], seen, i == 6); end
      end
      valid[0] = 0; res[0] = 3'd0;
      n_cmp++; if (sum[0] !== 8'd20) begin n_bad++; $display("FAIL gaps_total: got %0d want 20", sum[0]); end
   endtask

   task automatic test_clear();
      hard_reset();
      for (int i = 0; i < 2; i++) begin valid[0] = 1; res[0] = 3'd2; tick(); end
      clr[0] = 1; valid[0] = 1; res[0] = 3'd6;
      tick();
      clr[0] = 0;
      n_cmp++; if (sum[0] !== 8'd0 || cnt[0] !== 3'd0) begin n_bad++; $display("FAIL clear_accum: got s=%0d c=%0d want 0 0", sum[0], cnt[0]); end
      for (int i = 0; i < 4; i++) begin valid[0] = 1; res[0] = 3'd1; tick(); end
      valid[0] = 0; clr[0] = 1;
      tick();
      clr[0] = 0;
      n_cmp++; if (svalid[0] !== 1'b1 || sum[0] !== 8'd4 || cnt[0] !== 3'd4) begin n_bad++; $display("FAIL clear_in_hold: got v=%b s=%0d c=%0d want 1 4 4", svalid[0], sum[0], cnt[0]); end
      sready[0] = 1;
      tick();
      sready[0] = 0;
      n_cmp++; if (svalid[0] !== 1'b0) begin n_bad++; $display("FAIL clear_release: got %b want 0", svalid[0]); end
   endtask

   task automatic test_reset_in_hold();
      int vals[4] = '{3, 6, 1, 2};
      hard_reset();
      for (int i = 0; i < 4; i++) begin valid[0] = 1; res[0] = 3'(vals[i]); tick(); end
      valid[0] = 0;
      rst_n = 0;
      #1;
      n_cmp++; if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL rsthold_ready: got %b want 0", ready[0]); end
      tick();
      n_cmp++; if (svalid[0] !== 1'b0 || sum[0] !== 8'd0 || cnt[0] !== 3'd0) begin n_bad++; $display("FAIL rsthold_state: got v=%b s=%0d c=%0d want 0 0 0", svalid[0], sum[0], cnt[0]); end
      rst_n = 1;
      #1;
      n_cmp++; if (ready[0] !== 1'b1) begin n_bad++; $display("FAIL rsthold_release: got %b want 1", ready[0]); end
      valid[0] = 1; res[0] = 3'd3;
      tick();
      valid[0] = 0;
      #2 rst_n = 0;
      #2 rst_n = 1;
      tick();
      n_cmp++; if (sum[0] !== 8'd3 || cnt[0] !== 3'd1) begin n_bad++; $display("FAIL rst_glitch: got s=%0d c=%0d want 3 1", sum[0], cnt[0]); end
   endtask

   task automatic test_single_sample();
      hard_reset();
      valid[2] = 1; res[2] = 3'd5;
      tick();
      n_cmp++; if (svalid[2] !== 1'b1 || sum[2] !== 8'd5 || cnt[2] !== 3'd1) begin n_bad++; $display("FAIL single_first: got v=%b s=%0d c=%0d want 1 5 1", svalid[2], sum[2], cnt[2]); end
      res[2] = 3'd6;
      tick();
      n_cmp++; if (sum[2] !== 8'd5 || ready[2] !== 1'b0) begin n_bad++; $display("FAIL single_hold: got s=%0d r=%b want 5 0", sum[2], ready[2]); end
      valid[2] = 0; sready[2] = 1;
      tick();
      valid[2] = 1; res[2] = 3'd6;
      tick();
      valid[2] = 0;
      n_cmp++; if (svalid[2] !== 1'b1 || sum[2] !== 8'd6) begin n_bad++; $display("FAIL single_second: got v=%b s=%0d want 1 6", svalid[2], sum[2]); end
      sready[2] = 0;
   endtask

   task automatic test_random();
      hard_reset();
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         for (int d = 0; d < 3; d++) begin
            valid[d]  = $urandom_range(0, 3) != 0;
            res[d]    = valid[d] ? 3'($urandom_range(0, 6)) : 3'd0;
            clr[d]    = $urandom_range(0, 11) == 0;
            sready[d] = $urandom_range(0, 2) == 0;
         end
         tick();
         for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (sum[d] !== 8'(m_sum[d]) || cnt[d] !== 3'(m_cnt[d]) || svalid[d] !== m_hold[d] ||
                ovf[d] !== m_ovf[d] || ready[d] !== (!m_hold[d] && rst_n)) begin
               n_bad++;
               $display("FAIL rand[%0d] dut%0d: got s=%0d c=%0d v=%b o=%b r=%b want %0d %0d %b %b %b",
                        c, d, sum[d], cnt[d], svalid[d], ovf[d], ready[d],
                        m_sum[d], m_cnt[d], m_hold[d], m_ovf[d], !m_hold[d] && rst_n);
            end
         end
      end
      rst_n = 1;
      idle_all();
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         m_sum[d] = 0; m_cnt[d] = 0; m_hold[d] = 0; m_ovf[d] = 0;
      end
      idle_all();
      rst_n = 0;
      #1;
      test_reset();
      test_basic_window();
      test_back_pressure();
      test_saturation();
      test_valid_gaps();
      test_clear();
      test_reset_in_hold();
      test_single_sample();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
